// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the Execute stage: owns HI/LO and models MD latency
// with a countdown. Defining MDU_CANCEL_EN adds the cancel_i squash input.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
`ifdef MDU_CANCEL_EN
    input  logic        cancel_i,
`endif
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic        pwr_q, pwr_d;

    logic        cancel_s;
    logic        issue_s;
    logic        move_ok_s;
    logic        is_div_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic [31:0] num_s, den_s, q_mag_s, r_mag_s, quo_s, rem_s;

`ifdef MDU_CANCEL_EN
    assign cancel_s = cancel_i;
`else
    assign cancel_s = 1'b0;
`endif

    assign issue_s   = start_i && !cancel_s && (op_i >= OP_MULT) && (op_i <= OP_DIVU);
    assign move_ok_s = !start_i && !cancel_s;
    assign is_div_s  = (op_i == OP_DIV) || (op_i == OP_DIVU);

    // Result datapath: one multiplier and one magnitude divider with sign fix-up.
    always_comb begin
        if (op_i == OP_MULT) begin
            mul_a_s = {{32{a_i[31]}}, a_i};
            mul_b_s = {{32{b_i[31]}}, b_i};
        end else begin
            mul_a_s = {32'd0, a_i};
            mul_b_s = {32'd0, b_i};
        end
        prod_s = mul_a_s * mul_b_s;

        if (op_i == OP_DIV) begin
            num_s = a_i[31] ? (32'd0 - a_i) : a_i;
            den_s = b_i[31] ? (32'd0 - b_i) : b_i;
        end else begin
            num_s = a_i;
            den_s = b_i;
        end

        // A zero divisor never writes back; keep the divider inputs defined anyway.
        if (den_s == 32'd0) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = num_s / den_s;
            r_mag_s = num_s % den_s;
        end

        if ((op_i == OP_DIV) && (a_i[31] != b_i[31])) begin
            quo_s = 32'd0 - q_mag_s;
        end else begin
            quo_s = q_mag_s;
        end

        if ((op_i == OP_DIV) && a_i[31]) begin
            rem_s = 32'd0 - r_mag_s;
        end else begin
            rem_s = r_mag_s;
        end
    end

    // Next-state logic for the IDLE/RUN sequencer and the HI/LO registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    if (is_div_s) begin
                        cnt_d = DIV_CNT;
                        phi_d = rem_s;
                        plo_d = quo_s;
                        pwr_d = (b_i != 32'd0);
                    end else begin
                        cnt_d = MULT_CNT;
                        phi_d = prod_s[63:32];
                        plo_d = prod_s[31:0];
                        pwr_d = 1'b1;
                    end
                end else if (move_ok_s && (op_i == OP_MTHI)) begin
                    hi_d = a_i;
                end else if (move_ok_s && (op_i == OP_MTLO)) begin
                    lo_d = a_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Treat cnt<=1 as the last cycle so a corrupted zero count cannot stick.
                if (cnt_q <= 5'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b0;
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan cases, then randomized
// operations against an arithmetic reference model of HI/LO and busy timing.
module tb_mdu_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
`ifdef MDU_CANCEL_EN
        .cancel_i(cancel),
`endif
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic exp_busy);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    // Reference arithmetic: returns {hi, lo} for ops 1..4 with a nonzero divisor.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     q, r;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (o)
            3'd1: ref_result = sx * sy;
            3'd2: ref_result = ux * uy;
            3'd3: begin
                q = sx / sy;
                r = sx % sy;
                ref_result = {r[31:0], q[31:0]};
            end
            3'd4: begin
                q = ux / uy;
                r = ux % uy;
                ref_result = {r[31:0], q[31:0]};
            end
            default: ref_result = 64'd0;
        endcase
    endfunction

    task automatic run_md(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input bit inject);
        logic [63:0] r;
        int          n;
        bit          wr;
        n  = (o == 3'd1 || o == 3'd2) ? MULT_N : DIV_N;
        wr = !((o == 3'd3 || o == 3'd4) && bv == 32'd0);
        r  = wr ? ref_result(o, av, bv) : 64'd0;
        start = 1'b1; op = o; a = av; b = bv;
        chk_state("issue", 1'b0);
        tick();
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        for (int i = 1; i <= n; i++) begin
            chk_state($sformatf("run_op%0d_c%0d", o, i), 1'b1);
            if (inject && i == 2) begin
                start = 1'b1; op = 3'($urandom_range(1, 6)); a = $urandom; b = $urandom;
            end
            if (inject && i == 4) begin
                start = 1'b0; op = 3'($urandom_range(5, 6)); a = $urandom;
            end
            tick();
            start = 1'b0; op = 3'd0;
        end
        if (wr) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        chk_state($sformatf("done_op%0d", o), 1'b0);
    endtask

    task automatic move(input logic [2:0] o, input logic [31:0] v);
        start = 1'b0; op = o; a = v;
        tick();
        op = 3'd0;
        if (o == 3'd5) m_hi = v;
        else m_lo = v;
        chk_state($sformatf("move_op%0d", o), 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        m_hi = 32'd0; m_lo = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk_state("reset", 1'b0);

        // Test-plan vectors, with hard-coded expectations alongside the model.
        run_md(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("plan_mult.hi", hi, 32'hFFFF_FFFF);
        chk("plan_mult.lo", lo, 32'hFFFF_FFF1);
        run_md(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("plan_multu.hi", hi, 32'd1);
        chk("plan_multu.lo", lo, 32'hFFFF_FFFE);
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("plan_div.lo", lo, 32'hFFFF_FFFD);
        chk("plan_div.hi", hi, 32'hFFFF_FFFF);
        run_md(3'd4, 32'd100, 32'd7, 1'b0);
        chk("plan_divu.lo", lo, 32'd14);
        chk("plan_divu.hi", hi, 32'd2);
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("plan_divovf.lo", lo, 32'h8000_0000);
        chk("plan_divovf.hi", hi, 32'd0);
        move(3'd5, 32'h1234_5678);
        chk("plan_mthi.hi", hi, 32'h1234_5678);
        run_md(3'd4, 32'd55, 32'd0, 1'b1);
        chk("plan_div0.hi", hi, 32'h1234_5678);
        chk("plan_div0.lo", lo, 32'h8000_0000);

        // Ignored starts in IDLE: no-op and move opcodes with start high.
        for (int k = 0; k < 4; k++) begin
            start = 1'b1; op = (k == 0) ? 3'd0 : (k == 1) ? 3'd7 : (k == 2) ? 3'd5 : 3'd6;
            a = $urandom;
            tick();
            start = 1'b0; op = 3'd0;
            chk_state($sformatf("ign_start%0d", k), 1'b0);
        end

        // Reset in the third busy cycle discards the pending mult.
        start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0; op = 3'd0;
        tick();
        tick();
        chk_state("pre_reset_c3", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk_state("mid_reset", 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_state("post_reset", 1'b0);
        end

`ifdef MDU_CANCEL_EN
        move(3'd6, 32'hCAFE_0001);
        cancel = 1'b1; start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        tick();
        start = 1'b0; op = 3'd0; cancel = 1'b0;
        chk_state("cancel_start", 1'b0);
        tick();
        chk_state("cancel_start2", 1'b0);
        cancel = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
        tick();
        cancel = 1'b0; op = 3'd0;
        chk_state("cancel_mtlo", 1'b0);
`endif

        // Randomized back-to-back traffic with occasional corner operands.
        for (int k = 0; k < 30; k++) begin
            logic [2:0]  o;
            logic [31:0] av, bv;
            o  = 3'($urandom_range(1, 6));
            av = $urandom;
            bv = $urandom;
            if ($urandom_range(0, 5) == 0) bv = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                av = 32'h8000_0000;
                bv = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 9));
            if (o >= 3'd5) move(o, av);
            else run_md(o, av, bv, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the P7 five-stage pipeline. It sits in the Execute stage, owns the HI/LO registers, and sequences mult/multu/div/divu/mthi/mtlo. It drives `busy`, which the hazard unit combines with `start` to stall MD-class instructions in Decode. Result latency is modelled with a countdown counter; the arithmetic itself is computed at issue.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-31)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-31)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is mult/multu/div/divu this cycle
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
- a  in  32  forwarded rs value (FwdE1)
- b  in  32  forwarded rt value (FwdE2)
- cancel  in  1  exception/interrupt in M stage; present only with MDU_CANCEL_EN
- busy  out  1  operation in flight
- hi  out  32  HI register, read by mfhi
- lo  out  32  LO register, read by mflo

## Operation
- States: IDLE, RUN. Counter `cnt` is 5 bits wide.
- IDLE, start=1, op in 1..4: compute the 64-bit result into pending regs `phi`/`plo`. Load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- IDLE, start=1, op not in 1..4: ignored.
- IDLE, op=5 (mthi) or op=6 (mtlo), start=0: write `a` into hi or lo at the next edge. No busy, no state change.
- RUN: `cnt` decrements each cycle. In the cycle with `cnt`==1, at the edge: hi<=phi, lo<=plo, go to IDLE.
- RUN, start or mthi/mtlo: ignored. The hazard unit guarantees this never occurs; the bench checks that state is unaffected.
- mult: signed 32x32 product; hi=[63:32], lo=[31:0]. multu: unsigned product.
- div: lo = quotient truncated toward zero; hi = remainder, which carries the dividend's sign.
- div special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b==0, div or divu): full DIV_CYCLES busy period; hi/lo retain their prior values at completion.
- Reset (any state, including mid-RUN): state=IDLE, cnt=0, busy=0, hi=0, lo=0. The pending result is discarded.

## Timing
- Issue cycle T (start=1): busy=0 during T. busy=1 from T+1 through T+N, where N = MULT_CYCLES or DIV_CYCLES. busy=0 at T+N+1.
- hi/lo hold new values from T+N+1 onward. An mfhi/mflo in Decode stalls until busy falls.
- mthi/mtlo in cycle T: the new hi/lo value is visible at T+1.
- busy is a registered output: busy = (state==RUN).
- hi/lo are registered outputs with no combinational bypass.
- Back-to-back: a start at T+N+1 (first non-busy cycle) is accepted.

## Configuration
- MDU_CANCEL_EN defined: `cancel` port exists.
  - start with cancel=1 is ignored: no RUN, no busy.
  - mthi/mtlo with cancel=1 do not write.
  - An operation already in RUN completes normally.
- MDU_CANCEL_EN undefined: `cancel` port is absent; all starts and moves take effect unconditionally.

## Test plan
- mult a=0xFFFFFFFD (-3), b=5 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles, hi=1, lo=0xFFFFFFFE.
- Divides, 10 busy cycles each:
  - div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=100, b=7 → lo=14, hi=2.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi a=0x12345678, then divu b=0 → hi=0x12345678 at the cycle after mthi. After 10 busy cycles, hi/lo are unchanged. A start pulse injected mid-RUN has no effect.
- mult issued, then reset asserted at busy cycle 3 → next cycle busy=0, hi=lo=0. No later writeback occurs.
- With MDU_CANCEL_EN: start mult with cancel=1 → busy stays 0, hi/lo unchanged. mtlo with cancel=1 → lo unchanged.
